// File: rtl/div_unit.sv
// Purpose: iterative radix-2 restoring divider for DIV (signed) / DIVU (unsigned), 32-bit operands.
// Latency: fixed 34 cycles from the accepting edge to the done pulse, for every operand value.
// Backpressure: start/busy/done handshake; start is ignored while busy, with no queueing.
//
// Ports:
//   clk     in   1   clock, rising edge
//   rst     in   1   asynchronous active-high reset
//   start   in   1   request strobe, sampled only while idle
//   cancel  in   1   pipeline flush, aborts an operation in flight, blocks acceptance in idle
//   optr    in   5   operation select (ALUOptr_t): DIV = 5'd8, DIVU = 5'd9, all others ignored
//   A       in  32   dividend
//   B       in  32   divisor
//   busy    out  1   high whenever the unit is not idle
//   done    out  1   one-cycle pulse, result valid
//   result  out 64   {quotient, remainder}, held until the next completion
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        cancel,
    input  logic [4:0]  optr,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [63:0] result
);

    // ALUOptr_t encodings of the two operations this unit serves.
    localparam logic [4:0] OPTR_DIV  = 5'd8;
    localparam logic [4:0] OPTR_DIVU = 5'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_busy;
    logic        r_done;
    logic [63:0] r_result;
    logic [31:0] r_dvd;     // dividend magnitude, shifted out MSB first
    logic [31:0] r_dvs;     // divisor magnitude
    logic [31:0] r_rem;     // partial remainder
    logic [31:0] r_quo;     // quotient magnitude, shifted in LSB first
    logic [4:0]  r_cnt;
    logic        r_neg_q;
    logic        r_neg_r;

    logic        w_is_div;
    logic        w_accept;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_shift;
    logic [32:0] w_trial;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;

    assign w_is_div = (optr == OPTR_DIV);
    assign w_accept = start & ~cancel & (w_is_div | (optr == OPTR_DIVU));

    // Magnitudes; 0x80000000 maps to itself, which is the correct unsigned magnitude.
    assign w_a_mag = (w_is_div & A[31]) ? (32'd0 - A) : A;
    assign w_b_mag = (w_is_div & B[31]) ? (32'd0 - B) : B;

    // Restoring step. The partial remainder is always below the divisor, so the
    // shifted value is below twice the divisor and bit 32 of the trial is its sign.
    assign w_shift = {r_rem, r_dvd[31]};
    assign w_trial = w_shift - {1'b0, r_dvs};

    assign w_q_fix = r_neg_q ? (32'd0 - r_quo) : r_quo;
    assign w_r_fix = r_neg_r ? (32'd0 - r_rem) : r_rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= 64'd0;
            r_dvd    <= 32'd0;
            r_dvs    <= 32'd0;
            r_rem    <= 32'd0;
            r_quo    <= 32'd0;
            r_cnt    <= 5'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        // Signed divide by zero must return all-ones quotient and the
                        // raw dividend: suppressing the quotient negation gives that,
                        // and negating |A| for a negative A restores A exactly.
                        r_neg_q <= w_is_div & (A[31] ^ B[31]) & (B != 32'd0);
                        r_neg_r <= w_is_div & A[31];
                        r_dvd   <= w_a_mag;
                        r_dvs   <= w_b_mag;
                        r_rem   <= 32'd0;
                        r_quo   <= 32'd0;
                        r_cnt   <= 5'd31;
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (cancel) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_rem <= w_trial[32] ? w_shift[31:0] : w_trial[31:0];
                        r_quo <= {r_quo[30:0], ~w_trial[32]};
                        r_dvd <= {r_dvd[30:0], 1'b0};
                        if (r_cnt == 5'd0) begin
                            r_state <= S_FIX;
                        end else begin
                            r_cnt <= r_cnt - 5'd1;
                        end
                    end
                end
                S_FIX: begin
                    if (cancel) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_result <= {w_q_fix, w_r_fix};
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    localparam logic [4:0] OP_PLUS = 5'd0;
    localparam logic [4:0] OP_DIV  = 5'd8;
    localparam logic [4:0] OP_DIVU = 5'd9;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        cancel;
    logic [4:0]  optr;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_res = 64'd0;
    logic [63:0] mon_prev = 64'd0;

    div_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .cancel (cancel),
        .optr   (optr),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp_v);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse and flags result changes without done.
    always @(negedge clk) begin
        if (rst) begin
            mon_prev = 64'd0;
        end else begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 with result 0x%h, required no pending request", result);
                end else begin
                    check("result", result, exp_q.pop_front());
                end
            end
            if (result !== mon_prev) begin
                check("result_changes_only_with_done", {63'd0, done}, 64'd1);
                mon_prev = result;
            end
        end
    end

    // Called at #1 after a rising edge with the unit idle; returns in the first idle cycle after done.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_v, input int poke);
        int cyc;
        bit busy_ok;
        exp_q.push_back(exp_v);
        start = 1'b1; optr = op; A = a; B = b;
        @(posedge clk); #1;
        // Scramble operands while busy; the unit must have latched them already.
        start = 1'b0; optr = OP_DIVU; A = 32'hDEADBEEF; B = 32'h1;
        cyc = 1;
        busy_ok = 1'b1;
        while (!done && cyc < 100) begin
            if (!busy) busy_ok = 1'b0;
            start = (cyc == poke);
            if (cyc == poke) begin A = 32'd5; B = 32'd1; end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("latency", cyc, 64'd34);
        check("busy_during_op", {63'd0, busy_ok}, 64'd1);
        check("busy_at_done", {63'd0, busy}, 64'd1);
        last_res = exp_v;
        @(posedge clk); #1;
        check("busy_after_done", {63'd0, busy}, 64'd0);
        check("done_single_cycle", {63'd0, done}, 64'd0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cancel = 1'b0; optr = OP_PLUS; A = 32'd0; B = 32'd0;
        idle_cycles(2);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_result", result, 64'd0);
        rst = 1'b0;
        idle_cycles(1);

        run_op(OP_DIVU, 32'd100,        32'd7,          64'h0000000E_00000002, 0);
        run_op(OP_DIV,  32'hFFFFFFF9,   32'd2,          64'hFFFFFFFD_FFFFFFFF, 0);
        run_op(OP_DIV,  32'd7,          32'hFFFFFFFE,   64'hFFFFFFFD_00000001, 0);
        run_op(OP_DIVU, 32'h12345678,   32'd0,          64'hFFFFFFFF_12345678, 0);
        run_op(OP_DIV,  32'hFFFFFFFB,   32'd0,          64'hFFFFFFFF_FFFFFFFB, 0);
        run_op(OP_DIV,  32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, 0);
        run_op(OP_DIVU, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 0);
        // -100 / 7 = -14 rem -2, with a stray start in cycle 10.
        run_op(OP_DIV,  32'hFFFFFF9C,   32'd7,          64'hFFFFFFF2_FFFFFFFE, 10);
        idle_cycles(3);
        check("no_op_from_stray_start", {63'd0, busy}, 64'd0);

        // Cancel in cycle 20: idle in cycle 21, no done, result kept.
        start = 1'b1; optr = OP_DIVU; A = 32'd1000; B = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        idle_cycles(19);
        cancel = 1'b1;
        idle_cycles(1);
        cancel = 1'b0;
        check("cancel_busy", {63'd0, busy}, 64'd0);
        check("cancel_result_held", result, last_res);
        idle_cycles(40);
        check("cancel_result_still_held", result, last_res);

        // start with cancel in idle: not accepted.
        start = 1'b1; cancel = 1'b1; optr = OP_DIVU; A = 32'd9; B = 32'd3;
        idle_cycles(1);
        start = 1'b0; cancel = 1'b0;
        check("start_cancel_idle", {63'd0, busy}, 64'd0);
        idle_cycles(3);

        // Unsupported operation: not accepted.
        start = 1'b1; optr = OP_PLUS; A = 32'd9; B = 32'd3;
        idle_cycles(1);
        start = 1'b0;
        check("plus_rejected", {63'd0, busy}, 64'd0);
        idle_cycles(40);

        // Asynchronous reset mid-CALC.
        start = 1'b1; optr = OP_DIVU; A = 32'd50; B = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        idle_cycles(14);
        #3 rst = 1'b1;
        #1;
        check("async_rst_busy", {63'd0, busy}, 64'd0);
        check("async_rst_done", {63'd0, done}, 64'd0);
        check("async_rst_result", result, 64'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        last_res = 64'd0;
        run_op(OP_DIVU, 32'd9, 32'd3, 64'h00000003_00000000, 0);
        idle_cycles(5);

        check("scoreboard_drained", exp_q.size(), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
